// File: rtl/pf_pkg.sv
// Shared constants and types for the custom-float to IEEE-754 binary32 result converter.
package pf_pkg;

  localparam int unsigned CEXP_W      = 6;
  localparam int unsigned CFRAC_W     = 25;
  localparam int unsigned CBIAS       = 31;
  localparam int unsigned IEEE_BIAS   = 127;
  localparam int unsigned EXP_OFFSET  = IEEE_BIAS - CBIAS;
  localparam int unsigned IEEE_EXP_W  = 8;
  localparam int unsigned IEEE_FRAC_W = 23;
  localparam int unsigned WORK_W      = CFRAC_W + 1;
  localparam int unsigned STATUS_W    = 4;
  localparam int unsigned FLAGS_W     = 4;

  // flags_out bit positions
  localparam int unsigned FLAG_INEXACT  = 0;
  localparam int unsigned FLAG_INVALID  = 1;
  localparam int unsigned FLAG_INFINITY = 2;
  localparam int unsigned FLAG_ZERO     = 3;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StDecode    = 3'd1,
    StNormalize = 3'd2,
    StRound     = 3'd3,
    StHold      = 3'd4
  } pf_conv_state_t;

endpackage

// File: rtl/pf_rne_round.sv
// Round-to-nearest-even of a normalised 26-bit significand into a binary32 magnitude.
module pf_rne_round import pf_pkg::*; (
  input  logic [WORK_W-1:0]     work,
  input  logic [IEEE_EXP_W-1:0] wexp,
  output logic [30:0]           mag,
  output logic                  inexact
);

  logic [IEEE_FRAC_W-1:0] frac;
  logic                   guard;
  logic                   sticky;
  logic                   up;
  logic                   unused_hidden;

  // Hidden bit is implied by wexp; a mantissa carry ripples straight into the exponent.
  always_comb begin
    unused_hidden = work[WORK_W-1];
    frac          = work[WORK_W-2:2];
    guard         = work[1];
    sticky        = work[0];
    up            = guard & (sticky | frac[0]);
    inexact       = guard | sticky;
    mag           = {wexp, frac} + 31'(up);
  end

endmodule

// File: rtl/pf_custom_to_ieee754.sv
// Converts one custom float (1|6 exp bias 31|25 frac) plus status into IEEE-754 binary32.
module pf_custom_to_ieee754 import pf_pkg::*; #(
  parameter int unsigned CEXP_W    = 6,
  parameter int unsigned CFRAC_W   = 25,
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  input  logic [3:0]  status_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ieee_out,
  output logic [3:0]  flags_out,
  output logic [3:0]  status_out,
  output logic [2:0]  state_out
);

  pf_conv_state_t state_q, state_d;

  logic [31:0]           data_q, data_d;
  logic [STATUS_W-1:0]   status_q, status_d;
  logic [WORK_W-1:0]     work_q, work_d;
  logic [IEEE_EXP_W-1:0] wexp_q, wexp_d;
  logic [31:0]           ieee_q, ieee_d;
  logic [FLAGS_W-1:0]    flags_q, flags_d;

  logic               sign;
  logic [CEXP_W-1:0]  cexp;
  logic [CFRAC_W-1:0] cfrac;
  logic               exp_max;
  logic               exp_zero;
  logic               frac_zero;
  logic               accept;
  logic [30:0]        rnd_mag;
  logic               rnd_inexact;

  assign sign      = data_q[31];
  assign cexp      = data_q[CFRAC_W +: CEXP_W];
  assign cfrac     = data_q[CFRAC_W-1:0];
  assign exp_max   = &cexp;
  assign exp_zero  = ~|cexp;
  assign frac_zero = ~|cfrac;
  assign accept    = in_valid & in_ready;

  pf_rne_round u_round (
    .work    (work_q),
    .wexp    (wexp_q),
    .mag     (rnd_mag),
    .inexact (rnd_inexact)
  );

  always_ff @(posedge clock_100kHz) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (accept) state_d = StDecode;
      StDecode: begin
        if (exp_max || (exp_zero && frac_zero)) begin
          state_d = StHold;
        end else if (exp_zero) begin
          state_d = StNormalize;
        end else begin
          state_d = StRound;
        end
      end
      StNormalize: if (work_q[WORK_W-1]) state_d = StRound;
      StRound:     state_d = StHold;
      StHold:      if (out_ready) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = reset;
      StHold:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    status_d = status_q;
    work_d   = work_q;
    wexp_d   = wexp_q;
    ieee_d   = ieee_q;
    flags_d  = flags_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d   = data_in;
          status_d = status_in;
        end
      end
      StDecode: begin
        flags_d = '0;
        if (exp_max && frac_zero) begin
          ieee_d                 = {sign, 8'hFF, 23'd0};
          flags_d[FLAG_INFINITY] = 1'b1;
        end else if (exp_max) begin
          ieee_d                = NAN_CANON;
          flags_d[FLAG_INVALID] = 1'b1;
        end else if (exp_zero && frac_zero) begin
          ieee_d             = {sign, 31'd0};
          flags_d[FLAG_ZERO] = 1'b1;
        end else if (exp_zero) begin
          // Subnormal starts one binade above the hidden-bit position and walks down.
          work_d = {1'b0, cfrac};
          wexp_d = 8'(EXP_OFFSET + 1);
        end else begin
          work_d = {1'b1, cfrac};
          wexp_d = 8'(cexp) + 8'(EXP_OFFSET);
        end
      end
      StNormalize: begin
        if (!work_q[WORK_W-1]) begin
          work_d = work_q << 1;
          wexp_d = wexp_q - 8'd1;
        end
      end
      StRound: begin
        ieee_d                = {sign, rnd_mag};
        flags_d               = '0;
        flags_d[FLAG_INEXACT] = rnd_inexact;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_100kHz) begin
    if (!reset) begin
      data_q   <= '0;
      status_q <= '0;
      work_q   <= '0;
      wexp_q   <= '0;
      ieee_q   <= '0;
      flags_q  <= '0;
    end else begin
      data_q   <= data_d;
      status_q <= status_d;
      work_q   <= work_d;
      wexp_q   <= wexp_d;
      ieee_q   <= ieee_d;
      flags_q  <= flags_d;
    end
  end

  assign ieee_out   = ieee_q;
  assign flags_out  = flags_q;
  assign status_out = status_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_pf_custom_to_ieee754.sv
// Scoreboard bench for pf_custom_to_ieee754: expected results queued on drive, popped on output.
module tb_pf_custom_to_ieee754;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_in = '0;
  logic [3:0]  status_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ieee_out;
  logic [3:0]  flags_out;
  logic [3:0]  status_out;
  logic [2:0]  state_out;

  typedef struct {
    logic [31:0] ieee;
    logic [3:0]  flags;
    logic [3:0]  status;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pf_custom_to_ieee754 dut (
    .clock_100kHz (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .status_in    (status_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ieee_out     (ieee_out),
    .flags_out    (flags_out),
    .status_out   (status_out),
    .state_out    (state_out)
  );

  task automatic apply(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    data_in   = d;
    status_in = s;
    in_valid  = 1'b1;
    while (!in_ready && n < 64) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d edges, required 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      vectors++; miscompares++;
      $display("FAIL out_valid_timeout: out_valid=0 after %0d edges, required 1", lat);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, in_ready, state_out, ieee_out, flags_out, status_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got ov=%b ir=%b st=%0d ieee=%h fl=%h stat=%h, required all 0",
               out_valid, in_ready, state_out, ieee_out, flags_out, status_out);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_normal();
    logic [31:0] din [6] = '{32'h3E000000, 32'hC0800000, 32'h40000000,
                             32'h3E000003, 32'h3E000002, 32'h3FFFFFFF};
    logic [31:0] dexp[6] = '{32'h3F800000, 32'hC0200000, 32'h40000000,
                             32'h3F800001, 32'h3F800000, 32'h40000000};
    logic [3:0]  fexp[6] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    exp_t e;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{ieee: dexp[i], flags: fexp[i], status: 4'(i + 1), lat: 2});
      apply(din[i], 4'(i + 1));
      wait_out(lat);
      e = sb.pop_front();
      vectors += 4;
      if (ieee_out !== e.ieee) begin
        miscompares++; $display("FAIL normal_ieee[%0d]: got %h, required %h", i, ieee_out, e.ieee);
      end
      if (flags_out !== e.flags) begin
        miscompares++; $display("FAIL normal_flags[%0d]: got %h, required %h", i, flags_out, e.flags);
      end
      if (status_out !== e.status) begin
        miscompares++; $display("FAIL normal_status[%0d]: got %h, required %h", i, status_out, e.status);
      end
      if (lat != e.lat) begin
        miscompares++; $display("FAIL normal_latency[%0d]: got %0d, required %0d", i, lat, e.lat);
      end
      release_out();
    end
  endtask

  task automatic test_subnormal();
    logic [31:0] din [4] = '{32'h00000001, 32'h01000000, 32'h00000003, 32'h01000001};
    logic [31:0] dexp[4] = '{32'h24000000, 32'h30000000, 32'h24C00000, 32'h30000000};
    logic [3:0]  fexp[4] = '{4'h0, 4'h0, 4'h0, 4'h1};
    int          lexp[4] = '{28, 4, 27, 4};
    exp_t e;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{ieee: dexp[i], flags: fexp[i], status: 4'(8 + i), lat: lexp[i]});
      apply(din[i], 4'(8 + i));
      wait_out(lat);
      e = sb.pop_front();
      vectors += 4;
      if (ieee_out !== e.ieee) begin
        miscompares++; $display("FAIL subn_ieee[%0d]: got %h, required %h", i, ieee_out, e.ieee);
      end
      if (flags_out !== e.flags) begin
        miscompares++; $display("FAIL subn_flags[%0d]: got %h, required %h", i, flags_out, e.flags);
      end
      if (status_out !== e.status) begin
        miscompares++; $display("FAIL subn_status[%0d]: got %h, required %h", i, status_out, e.status);
      end
      if (lat != e.lat) begin
        miscompares++; $display("FAIL subn_latency[%0d]: got %0d, required %0d", i, lat, e.lat);
      end
      release_out();
    end
  endtask

  task automatic test_specials();
    logic [31:0] din [6] = '{32'h7E000000, 32'hFE000000, 32'h7E000001,
                             32'h80000000, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] dexp[6] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000,
                             32'h80000000, 32'h00000000, 32'h7FC00000};
    logic [3:0]  fexp[6] = '{4'h4, 4'h4, 4'h2, 4'h8, 4'h8, 4'h2};
    logic [3:0]  sexp[6] = '{4'hA, 4'h5, 4'hA, 4'h0, 4'hF, 4'h3};
    exp_t e;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{ieee: dexp[i], flags: fexp[i], status: sexp[i], lat: 1});
      apply(din[i], sexp[i]);
      wait_out(lat);
      e = sb.pop_front();
      vectors += 4;
      if (ieee_out !== e.ieee) begin
        miscompares++; $display("FAIL spec_ieee[%0d]: got %h, required %h", i, ieee_out, e.ieee);
      end
      if (flags_out !== e.flags) begin
        miscompares++; $display("FAIL spec_flags[%0d]: got %h, required %h", i, flags_out, e.flags);
      end
      if (status_out !== e.status) begin
        miscompares++; $display("FAIL spec_status[%0d]: got %h, required %h", i, status_out, e.status);
      end
      if (lat != e.lat) begin
        miscompares++; $display("FAIL spec_latency[%0d]: got %0d, required %0d", i, lat, e.lat);
      end
      release_out();
    end
  endtask

  task automatic test_hold_stall();
    exp_t e;
    int   lat;
    int   bad = 0;
    sb.push_back('{ieee: 32'h3F800001, flags: 4'h1, status: 4'h6, lat: 2});
    apply(32'h3E000003, 4'h6);
    wait_out(lat);
    e = sb.pop_front();
    // Offer a competing word while stalled; it must not be taken.
    data_in   = 32'h7E000000;
    status_in = 4'h9;
    in_valid  = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== 3'd4 ||
          ieee_out !== e.ieee || flags_out !== e.flags || status_out !== e.status) bad++;
    end
    in_valid = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL hold_stable: got %0d unstable cycles (ieee=%h fl=%h), required 0",
               bad, ieee_out, flags_out);
    end
    release_out();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: got ov=%b ir=%b, required ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    sb.push_back('{ieee: 32'hC0200000, flags: 4'h0, status: 4'h1, lat: 2});
    sb.push_back('{ieee: 32'h7F800000, flags: 4'h4, status: 4'h2, lat: 1});
    data_in   = 32'hC0800000;
    status_in = 4'h1;
    in_valid  = 1'b1;
    while (!in_ready) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    // Second word waits with in_valid high while the first is in flight.
    data_in   = 32'h7E000000;
    status_in = 4'h2;
    wait_out(lat);
    e = sb.pop_front();
    vectors += 2;
    if (ieee_out !== e.ieee || status_out !== e.status) begin
      miscompares++;
      $display("FAIL b2b_first: got %h/%h, required %h/%h", ieee_out, status_out, e.ieee, e.status);
    end
    if (lat != e.lat) begin
      miscompares++; $display("FAIL b2b_first_latency: got %0d, required %0d", lat, e.lat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || state_out !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_idle_after_xfer: got ir=%b st=%0d, required ir=1 st=0", in_ready, state_out);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    e = sb.pop_front();
    vectors += 2;
    if (ieee_out !== e.ieee || flags_out !== e.flags || status_out !== e.status) begin
      miscompares++;
      $display("FAIL b2b_second: got %h/%h/%h, required %h/%h/%h",
               ieee_out, flags_out, status_out, e.ieee, e.flags, e.status);
    end
    if (lat != e.lat) begin
      miscompares++; $display("FAIL b2b_second_latency: got %0d, required %0d", lat, e.lat);
    end
    release_out();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat;
    int   seen = 0;
    apply(32'h00000001, 4'hC);
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (state_out !== 3'd2) begin
      miscompares++; $display("FAIL abort_in_normalize: got state=%0d, required 2", state_out);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (state_out !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || ieee_out !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_reset: got st=%0d ov=%b ir=%b ieee=%h, required 0/0/0/0",
               state_out, out_valid, in_ready, ieee_out);
    end
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL abort_no_emit: got %0d valid cycles, required 0", seen);
    end
    sb.push_back('{ieee: 32'h40000000, flags: 4'h0, status: 4'h7, lat: 2});
    apply(32'h40000000, 4'h7);
    wait_out(lat);
    e = sb.pop_front();
    vectors++;
    if (ieee_out !== e.ieee || flags_out !== e.flags || status_out !== e.status || lat != e.lat) begin
      miscompares++;
      $display("FAIL abort_recover: got %h/%h/%h lat %0d, required %h/%h/%h lat %0d",
               ieee_out, flags_out, status_out, lat, e.ieee, e.flags, e.status, e.lat);
    end
    release_out();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_subnormal();
    test_specials();
    test_hold_stall();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
